// File: rtl/arf_pkg.sv
// Shared definitions for the parametrised address register file.
package arf_pkg;

   localparam int unsigned FS_W = 2;

   typedef logic [FS_W-1:0] funsel_t;

   localparam funsel_t FS_DEC  = 2'b00;
   localparam funsel_t FS_INC  = 2'b01;
   localparam funsel_t FS_LOAD = 2'b10;
   localparam funsel_t FS_CLR  = 2'b11;

endpackage : arf_pkg

// File: rtl/arf_cell.sv
// One address register: dec/inc/load/clear with saturate-or-wrap at the
// unsigned bounds, plus a combinational flag when an enabled inc/dec hits a bound.
module arf_cell
   import arf_pkg::*;
#(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             e_i,
   input  logic [1:0]       funsel_i,
   input  logic             sat_en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic             hit_c_o
);

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Next value and bound detection; a bound hit flags in both modes.
   always_comb begin
      q_d     = q_q;
      hit_c_o = 1'b0;
      if (e_i) begin
         case (funsel_i)
            FS_DEC: begin
               if (q_q == ALL_ZERO) begin
                  hit_c_o = 1'b1;
                  q_d     = sat_en_i ? ALL_ZERO : ALL_ONES;
               end else begin
                  q_d = q_q - WIDTH'(1);
               end
            end
            FS_INC: begin
               if (q_q == ALL_ONES) begin
                  hit_c_o = 1'b1;
                  q_d     = sat_en_i ? ALL_ONES : ALL_ZERO;
               end else begin
                  q_d = q_q + WIDTH'(1);
               end
            end
            FS_LOAD: q_d = d_i;
            FS_CLR:  q_d = ALL_ZERO;
            default: q_d = q_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule : arf_cell

// File: rtl/arf_param.sv
// Parametrised address register file: multi-hot shared-function writes,
// two combinational read ports, wrap-event flag and automatic PC history.
module arf_param
   import arf_pkg::*;
#(
   parameter int unsigned      WIDTH    = 8,
   parameter int unsigned      NREGS    = 4,
   parameter int unsigned      SEL_W    = $clog2(NREGS),
   parameter int unsigned      PC_IDX   = 3,
   parameter int unsigned      PCP_IDX  = 2,
   parameter int unsigned      SP_IDX   = 1,
   parameter logic [WIDTH-1:0] SP_RESET = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i,
   input  logic [1:0]       funsel,
   input  logic [NREGS-1:0] r_sel,
   input  logic             sat_en,
   input  logic [SEL_W-1:0] out_a_sel,
   input  logic [SEL_W-1:0] out_b_sel,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             wrap_evt
);

   localparam int unsigned NSLOT = 32'(1) << SEL_W;

   if (NREGS < 4 || SEL_W < $clog2(NREGS) ||
       PC_IDX >= NREGS || PCP_IDX >= NREGS || SP_IDX >= NREGS ||
       PC_IDX == PCP_IDX || PC_IDX == SP_IDX || PCP_IDX == SP_IDX) begin : g_param_err
      $error("arf_param: NREGS/SEL_W/PC_IDX/PCP_IDX/SP_IDX parameters are inconsistent");
   end

   logic [WIDTH-1:0] q [NREGS];
   logic [WIDTH-1:0] slot [NSLOT];
   logic [NREGS-1:0] hit_c;
   logic             pc_auto_c;
   logic             wrap_q;
   logic             wrap_d;

   // PC written without an explicit PC_past write: PC_past captures the old PC.
   assign pc_auto_c = r_sel[PC_IDX] & ~r_sel[PCP_IDX];

   for (genvar k = 0; k < NREGS; k++) begin : g_cell
      logic             e_c;
      logic [1:0]       fs_c;
      logic [WIDTH-1:0] d_c;

      if (k == PCP_IDX) begin : g_pcp
         assign e_c  = r_sel[k] | pc_auto_c;
         assign fs_c = r_sel[k] ? funsel : FS_LOAD;
         assign d_c  = r_sel[k] ? i : q[PC_IDX];
      end else begin : g_std
         assign e_c  = r_sel[k];
         assign fs_c = funsel;
         assign d_c  = i;
      end

      arf_cell #(
         .WIDTH   (WIDTH),
         .RST_VAL ((k == SP_IDX) ? SP_RESET : {WIDTH{1'b0}})
      ) u_cell (
         .clk      (clk),
         .rst_n    (rst_n),
         .e_i      (e_c),
         .funsel_i (fs_c),
         .sat_en_i (sat_en),
         .d_i      (d_c),
         .q_o      (q[k]),
         .hit_c_o  (hit_c[k])
      );
   end

   // Selects beyond NREGS land on zero-filled slots.
   for (genvar k = 0; k < NSLOT; k++) begin : g_slot
      if (k < NREGS) begin : g_reg
         assign slot[k] = q[k];
      end else begin : g_zero
         assign slot[k] = {WIDTH{1'b0}};
      end
   end

   assign out_a = slot[out_a_sel];
   assign out_b = slot[out_b_sel];

   assign wrap_d = |hit_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign wrap_evt = wrap_q;

endmodule : arf_param

// File: tb/tb_arf_param.sv
// Bench for arf_param: directed scenarios plus randomized traffic against a
// value-level model of the register file.
module tb_arf_param;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned NREGS = 4;
   localparam int unsigned SEL_W = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [1:0]       funsel = '0;
   logic [NREGS-1:0] r_sel = '0;
   logic             sat_en = 1'b0;
   logic [SEL_W-1:0] out_a_sel = '0;
   logic [SEL_W-1:0] out_b_sel = '0;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic             wrap_evt;

   int checks = 0;
   int errors = 0;

   int mdl [NREGS];
   int mdl_wrap;

   arf_param dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i         (din),
      .funsel    (funsel),
      .r_sel     (r_sel),
      .sat_en    (sat_en),
      .out_a_sel (out_a_sel),
      .out_b_sel (out_b_sel),
      .out_a     (out_a),
      .out_b     (out_b),
      .wrap_evt  (wrap_evt)
   );

   always #5 clk = ~clk;

   function automatic void mdl_reset();
      for (int k = 0; k < NREGS; k++) mdl[k] = 0;
      mdl[1]   = 255;
      mdl_wrap = 0;
   endfunction

   // Register file semantics on one rising edge, in plain integer arithmetic.
   function automatic void mdl_edge(input logic [3:0] rs, input int fs, input int d, input int sat);
      int nxt [NREGS];
      int ev;
      ev = 0;
      for (int k = 0; k < NREGS; k++) begin
         nxt[k] = mdl[k];
         if (rs[k]) begin
            case (fs)
               0: if (mdl[k] == 0) begin ev = 1; nxt[k] = sat ? 0 : 255; end
                  else nxt[k] = mdl[k] - 1;
               1: if (mdl[k] == 255) begin ev = 1; nxt[k] = sat ? 255 : 0; end
                  else nxt[k] = mdl[k] + 1;
               2: nxt[k] = d;
               default: nxt[k] = 0;
            endcase
         end
      end
      if (rs[3] && !rs[2]) nxt[2] = mdl[3];
      for (int k = 0; k < NREGS; k++) mdl[k] = nxt[k];
      mdl_wrap = ev;
   endfunction

   task automatic drive_edge(input logic [3:0] rs, input int fs, input int d, input int sat);
      r_sel  = rs;
      funsel = 2'(fs);
      din    = 8'(d);
      sat_en = sat[0];
      @(posedge clk);
      mdl_edge(rs, fs, d, sat);
      #1;
      r_sel = '0;
   endtask

   task automatic read2(input int ka, input int kb, output logic [7:0] va, output logic [7:0] vb);
      out_a_sel = 2'(ka);
      out_b_sel = 2'(kb);
      #1;
      va = out_a;
      vb = out_b;
   endtask

   task automatic test_reset();
      logic [7:0] va, vb;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mdl_reset();
      read2(1, 0, va, vb);
      checks++;
      if (va !== 8'hFF) begin errors++; $display("FAIL reset_sp: got %h want ff", va); end
      checks++;
      if (vb !== 8'h00) begin errors++; $display("FAIL reset_ar: got %h want 00", vb); end
      checks++;
      if (wrap_evt !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap_evt); end
      @(negedge clk);
      rst_n = 1'b1;
      drive_edge(4'b1111, 2, 8'h5A, 0);
      // Asynchronous pulse between edges must clear without a clock.
      #1;
      rst_n = 1'b0;
      #1;
      mdl_reset();
      for (int k = 0; k < NREGS; k++) begin
         read2(k, NREGS - 1 - k, va, vb);
         checks++;
         if (va !== 8'(mdl[k])) begin errors++; $display("FAIL async_reset_a r%0d: got %h want %h", k, va, 8'(mdl[k])); end
         checks++;
         if (vb !== 8'(mdl[NREGS-1-k])) begin errors++; $display("FAIL async_reset_b r%0d: got %h want %h", NREGS-1-k, vb, 8'(mdl[NREGS-1-k])); end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_multi_load();
      logic [7:0] va, vb;
      drive_edge(4'b1001, 2, 8'h3C, 0);
      read2(3, 0, va, vb);
      checks++;
      if (va !== 8'h3C) begin errors++; $display("FAIL multi_load_pc: got %h want 3c", va); end
      checks++;
      if (vb !== 8'h3C) begin errors++; $display("FAIL multi_load_ar: got %h want 3c", vb); end
      read2(2, 2, va, vb);
      checks++;
      if (va !== 8'h00 || vb !== 8'h00) begin errors++; $display("FAIL multi_load_pcp: got %h/%h want 00/00", va, vb); end
   endtask

   task automatic test_pc_history();
      logic [7:0] va, vb;
      drive_edge(4'b1000, 2, 8'h10, 0);
      drive_edge(4'b1000, 1, 0, 0);
      read2(3, 2, va, vb);
      checks++;
      if (va !== 8'h11) begin errors++; $display("FAIL pc_inc: got %h want 11", va); end
      checks++;
      if (vb !== 8'h10) begin errors++; $display("FAIL pc_past_capture: got %h want 10", vb); end
      drive_edge(4'b1100, 3, 0, 0);
      read2(3, 2, va, vb);
      checks++;
      if (va !== 8'h00 || vb !== 8'h00) begin errors++; $display("FAIL pc_explicit_wins: got %h/%h want 00/00", va, vb); end
   endtask

   task automatic test_wrap();
      logic [7:0] va, vb;
      drive_edge(4'b0010, 2, 8'hFF, 0);
      drive_edge(4'b0010, 1, 0, 0);
      read2(1, 1, va, vb);
      checks++;
      if (va !== 8'h00) begin errors++; $display("FAIL wrap_inc_sp: got %h want 00", va); end
      checks++;
      if (wrap_evt !== 1'b1) begin errors++; $display("FAIL wrap_evt_set: got %b want 1", wrap_evt); end
      drive_edge(4'b0000, 1, 0, 0);
      checks++;
      if (wrap_evt !== 1'b0) begin errors++; $display("FAIL wrap_evt_clear: got %b want 0", wrap_evt); end
      drive_edge(4'b0001, 2, 8'h00, 0);
      drive_edge(4'b0001, 0, 0, 0);
      read2(0, 0, va, vb);
      checks++;
      if (va !== 8'hFF || wrap_evt !== 1'b1) begin errors++; $display("FAIL wrap_dec_ar: got %h/%b want ff/1", va, wrap_evt); end
   endtask

   task automatic test_saturate();
      logic [7:0] va, vb;
      drive_edge(4'b0001, 2, 8'h00, 1);
      drive_edge(4'b0001, 0, 0, 1);
      read2(0, 0, va, vb);
      checks++;
      if (va !== 8'h00 || wrap_evt !== 1'b1) begin errors++; $display("FAIL sat_dec: got %h/%b want 00/1", va, wrap_evt); end
      drive_edge(4'b0001, 2, 8'hFE, 1);
      drive_edge(4'b0001, 1, 0, 1);
      read2(0, 0, va, vb);
      checks++;
      if (va !== 8'hFF || wrap_evt !== 1'b0) begin errors++; $display("FAIL sat_inc1: got %h/%b want ff/0", va, wrap_evt); end
      drive_edge(4'b0001, 1, 0, 1);
      read2(0, 0, va, vb);
      checks++;
      if (va !== 8'hFF || wrap_evt !== 1'b1) begin errors++; $display("FAIL sat_inc2: got %h/%b want ff/1", va, wrap_evt); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] va, vb;
      @(negedge clk);
      r_sel  = 4'b1111;
      funsel = 2'b10;
      din    = 8'hAA;
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      mdl_reset();
      for (int k = 0; k < NREGS; k++) begin
         read2(k, k, va, vb);
         checks++;
         if (va !== 8'(mdl[k]) || vb !== 8'(mdl[k])) begin errors++; $display("FAIL reset_mid r%0d: got %h/%h want %h", k, va, vb, 8'(mdl[k])); end
      end
      @(negedge clk);
      r_sel = '0;
      rst_n = 1'b1;
      drive_edge(4'b0001, 2, 8'h55, 0);
      for (int k = 0; k < NREGS; k++) begin
         read2(k, NREGS - 1 - k, va, vb);
         checks++;
         if (va !== 8'(mdl[k])) begin errors++; $display("FAIL reset_release r%0d: got %h want %h", k, va, 8'(mdl[k])); end
      end
      checks++;
      if (wrap_evt !== 1'b0) begin errors++; $display("FAIL reset_release_wrap: got %b want 0", wrap_evt); end
   endtask

   task automatic test_random();
      logic [7:0] va, vb;
      int d;
      int pick;
      for (int n = 0; n < 300; n++) begin
         pick = int'($urandom_range(0, 4));
         case (pick)
            0: d = 0;
            1: d = 255;
            2: d = 1;
            3: d = 254;
            default: d = int'($urandom_range(0, 255));
         endcase
         drive_edge(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), d, int'($urandom_range(0, 1)));
         for (int k = 0; k < NREGS; k++) begin
            read2(k, NREGS - 1 - k, va, vb);
            checks++;
            if (va !== 8'(mdl[k])) begin errors++; $display("FAIL rand_a r%0d iter %0d: got %h want %h", k, n, va, 8'(mdl[k])); end
            checks++;
            if (vb !== 8'(mdl[NREGS-1-k])) begin errors++; $display("FAIL rand_b r%0d iter %0d: got %h want %h", NREGS-1-k, n, vb, 8'(mdl[NREGS-1-k])); end
         end
         checks++;
         if (wrap_evt !== mdl_wrap[0]) begin errors++; $display("FAIL rand_wrap iter %0d: got %b want %0d", n, wrap_evt, mdl_wrap); end
      end
   endtask

   initial begin
      test_reset();
      test_multi_load();
      test_pc_history();
      test_wrap();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_arf_param

// File: doc/arf_param.md
Name: arf_param

Overview:
- Parametrised address register file: NREGS general address registers of WIDTH bits.
- Shared function select applied to every register in a one-hot/multi-hot enable mask; two independent combinational read ports.
- Adds three things to the fixed 4x8 file:
  - saturate/wrap mode
  - registered wrap-event flag
  - automatic PC-history capture (previous PC copied into the PC_past slot whenever PC is modified)
- Sits between the ALU/bus mux and the memory address path.

Parameters:
- WIDTH, 8, data width of every register and port.
- NREGS, 4, number of registers (>=4).
- SEL_W, $clog2(NREGS), width of read selects.
- PC_IDX, 3, index of program counter.
- PCP_IDX, 2, index of PC_past (history) register.
- SP_IDX, 1, index of stack pointer.
- SP_RESET, {WIDTH{1'b1}}, reset value of SP.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- i  in  WIDTH  load data.
- funsel  in  2  operation: 00 decrement, 01 increment, 10 load i, 11 clear.
- r_sel  in  NREGS  write-enable mask, bit k enables register k.
- sat_en  in  1  1 = inc/dec saturate at bounds, 0 = wrap modulo 2^WIDTH.
- out_a_sel  in  SEL_W  read select A.
- out_b_sel  in  SEL_W  read select B.
- out_a  out  WIDTH  contents of register out_a_sel.
- out_b  out  WIDTH  contents of register out_b_sel.
- wrap_evt  out  1  registered; 1 for one cycle after any enabled inc/dec crossed a bound.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers to 0, except SP = SP_RESET.
  - wrap_evt = 0.
  - Reset asserted mid-cycle overrides any pending write; release is synchronous to the next clk edge with no extra latency.
- Writes: on rising clk edge, each register k with r_sel[k]=1 applies funsel. Registers with r_sel[k]=0 hold. r_sel=0 is a no-op.
- Arithmetic: WIDTH-bit unsigned.
  - Increment at all-ones: sat_en=1 holds all-ones; sat_en=0 gives 0.
  - Decrement at 0: sat_en=1 holds 0; sat_en=0 gives all-ones.
  - Either case sets wrap_evt=1 on that edge, in both modes.
  - wrap_evt = OR over enabled registers; cleared on any edge with no bound event.
- PC history:
  - When r_sel[PC_IDX]=1 and r_sel[PCP_IDX]=0, PC_past loads the pre-edge PC value on the same edge (all four funsel codes).
  - When r_sel[PCP_IDX]=1, the explicit funsel operation on PC_past takes priority; no auto-capture.
- Reads:
  - Purely combinational from current register state; no write-through bypass.
  - A write is visible on out_a/out_b after the edge (latency 1 cycle from write to read).
  - Both ports may select the same register.
  - A select >= NREGS (NREGS not a power of two) reads 0.
- Parameter checks: PC_IDX, PCP_IDX, SP_IDX must be distinct and < NREGS; violation is an elaboration error.
- No X propagation: all outputs defined from reset onward.

Decomposition:
- Shared package arf_pkg: funsel encodings FS_DEC=2'b00, FS_INC=2'b01, FS_LOAD=2'b10, FS_CLR=2'b11.
- Sub-module arf_cell:
  - one WIDTH-bit register with e, funsel, sat_en, d, reset-value parameter.
  - outputs q and a combinational bound-hit flag.
  - instantiated NREGS times via generate; the PC_past instance gets a muxed load path for auto-capture.
- Read muxes and the wrap_evt OR-reduce stay in arf_param.

Test Plan:
- Reset check:
  - pulse rst_n low between clock edges; check asynchronous clear.
  - out_a_sel=SP_IDX, out_b_sel=0 -> out_a=8'hFF, out_b=8'h00, wrap_evt=0.
- Multi-hot load and dual read:
  - r_sel=4'b1001, funsel=10, i=8'h3C, one edge.
  - Read A=3, B=0 -> both 8'h3C; PC_past=8'h00 (old PC captured).
- PC history:
  - PC=8'h10; r_sel=4'b1000, funsel=01 -> PC=8'h11, PC_past=8'h10.
  - Then r_sel=4'b1100, funsel=11 -> PC=0, PC_past=0 (explicit wins).
- Wrap mode:
  - sat_en=0, SP=8'hFF, r_sel=4'b0010, funsel=01 -> SP=8'h00, wrap_evt=1 for exactly one cycle.
  - Next idle cycle -> wrap_evt=0.
- Saturate mode:
  - sat_en=1, AR=8'h00, funsel=00 on AR -> AR stays 8'h00, wrap_evt=1.
  - AR=8'hFE incremented twice -> 8'hFF, 8'hFF; wrap_evt 0 then 1.
- Reset mid-operation:
  - Assert rst_n low coincident with a load of 8'hAA to all registers (r_sel=4'b1111).
  - All registers return to reset values; no 8'hAA visible after release.
